// File: rtl/fft_control_if.sv
// Handshake and sequencing bundle between the FFT control unit and its datapath/stimulus side.
// The slave modport is the controller's view; the master modport drives start/hold.
interface fft_control_if #(
  parameter int AWL = 5,
  parameter int LWL = 3
);
  logic           start;
  logic           hold;
  logic           bf_valid;
  logic [AWL-2:0] bf_idx;
  logic [LWL-1:0] lay_idx;
  logic           w_en;
  logic           w_lay_en;
  logic           busy;
  logic           done;

  modport master (
    output start, hold,
    input  bf_valid, bf_idx, lay_idx, w_en, w_lay_en, busy, done
  );

  modport slave (
    input  start, hold,
    output bf_valid, bf_idx, lay_idx, w_en, w_lay_en, busy, done
  );
endinterface

// File: rtl/fft_control_unit.sv
// Sequencer for an in-place radix-2 FFT: walks AWL layers of 2^(AWL-1) butterflies,
// with a pipeline-flush gap after each layer, and drives the twiddle-address generator strobes.
module fft_control_unit #(
  parameter int AWL     = 5,
  parameter int LWL     = 3,
  parameter int GAP_CYC = 4
) (
  input  logic          clk,
  input  logic          rst,
  fft_control_if.slave  bus
);

  localparam int BWL = AWL - 1;
  localparam int GCW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [BWL-1:0] BF_LAST  = {BWL{1'b1}};
  localparam logic [LWL-1:0] LAY_LAST = LWL'(AWL - 1);
  localparam logic [GCW-1:0] GAP_LOAD = GCW'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, RUN, GAP, FIN} state_t;

  state_t         state;
  logic [BWL-1:0] bf_idx;
  logic [LWL-1:0] lay_idx;
  logic [GCW-1:0] gap_cnt;
  logic           busy;
  logic           done;
  logic           issue;

  // Issue strobes stay combinational so a stall suppresses the butterfly in the same cycle.
  assign issue        = (state == RUN) && !bus.hold;
  assign bus.bf_valid = issue;
  assign bus.w_en     = issue;
  assign bus.w_lay_en = issue && (bf_idx == BF_LAST);
  assign bus.bf_idx   = bf_idx;
  assign bus.lay_idx  = lay_idx;
  assign bus.busy     = busy;
  assign bus.done     = done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bf_idx  <= '0;
      lay_idx <= '0;
      gap_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            state   <= RUN;
            busy    <= 1'b1;
            bf_idx  <= '0;
            lay_idx <= '0;
          end
        end
        RUN: begin
          if (!bus.hold) begin
            if (bf_idx == BF_LAST) begin
              bf_idx  <= '0;
              gap_cnt <= GAP_LOAD;
              state   <= GAP;
            end else begin
              bf_idx <= bf_idx + BWL'(1);
            end
          end
        end
        // The gap counter runs regardless of hold so the butterfly pipeline always drains.
        GAP: begin
          if (gap_cnt == '0) begin
            if (lay_idx < LAY_LAST) begin
              lay_idx <= lay_idx + LWL'(1);
              state   <= RUN;
            end else begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            gap_cnt <= gap_cnt - GCW'(1);
          end
        end
        FIN: begin
          state   <= IDLE;
          done    <= 1'b0;
          lay_idx <= '0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
